// File: rtl/mips_lsu.sv
// mips_lsu: sequenced load/store unit between the core EX stage and a
// fixed-latency, byte-laned, big-endian data memory.
// Ports:
//   clk, rst_b             clock, synchronous active-low reset
//   req_valid/req_ready    request handshake; req_op/req_addr/req_wdata payload
//   resp_valid             one-cycle completion pulse
//   resp_rdata/resp_err    load result (extended per op) and misalignment flag
//   busy                   unit not idle
//   mem_addr               word-aligned memory address
//   mem_data_out           read lanes from memory, lane 0 = most significant byte
//   mem_data_in            write lanes to memory, same ordering
//   mem_write_en           full-word write strobe
module mips_lsu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy,
  output logic [XLEN-1:0] mem_addr,
  input  logic [7:0]      mem_data_out [0:XLEN/8-1],
  output logic [7:0]      mem_data_in  [0:XLEN/8-1],
  output logic            mem_write_en
);
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LF  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SF  = 3'd7;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [OFF_W-1:0] off_q, off_nxt;
  logic [15:0]      wdata_q, wdata_nxt;
  logic             req_ready_nxt, busy_nxt, resp_valid_nxt, resp_err_nxt, mem_write_en_nxt;
  logic [XLEN-1:0]  resp_rdata_nxt, mem_addr_nxt;
  logic [7:0]       mem_data_in_nxt [0:NBYTES-1];

  logic [OFF_W-1:0] req_off_c, off_hi_c;
  logic             is_half_c, is_full_c, misaligned_c, is_load_q_c;
  logic [7:0]       ld_byte_c;
  logic [15:0]      ld_half_c;
  logic [XLEN-1:0]  ld_full_c, ld_result_c;
  logic [7:0]       sf_lanes_c    [0:NBYTES-1];
  logic [7:0]       merge_lanes_c [0:NBYTES-1];

  // Request decode, load extraction and store lane merge.
  always_comb begin
    req_off_c    = OFF_W'(req_addr % XLEN'(NBYTES));
    is_half_c    = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    is_full_c    = (req_op == OP_LF) || (req_op == OP_SF);
    misaligned_c = (is_half_c && req_off_c[0]) || (is_full_c && (req_off_c != '0));
    is_load_q_c  = (op_q < OP_SB);
    off_hi_c     = off_q + OFF_W'(1);

    ld_byte_c = mem_data_out[off_q];
    ld_half_c = {mem_data_out[off_q], mem_data_out[off_hi_c]};
    ld_full_c = '0;
    for (int k = 0; k < NBYTES; k++) begin
      ld_full_c[XLEN-1-8*k -: 8] = mem_data_out[k];
    end

    case (op_q)
      OP_LB:   ld_result_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c};
      OP_LH:   ld_result_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c};
      OP_LF:   ld_result_c = ld_full_c;
      OP_LBU:  ld_result_c = XLEN'(ld_byte_c);
      OP_LHU:  ld_result_c = XLEN'(ld_half_c);
      default: ld_result_c = '0;
    endcase

    // Right-aligned store data lands big-endian: lane 0 gets the top byte.
    for (int k = 0; k < NBYTES; k++) begin
      sf_lanes_c[k]    = req_wdata[XLEN-1-8*k -: 8];
      merge_lanes_c[k] = mem_data_out[k];
    end
    if (op_q == OP_SB) begin
      merge_lanes_c[off_q] = wdata_q[7:0];
    end else if (op_q == OP_SH) begin
      merge_lanes_c[off_q]    = wdata_q[15:8];
      merge_lanes_c[off_hi_c] = wdata_q[7:0];
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    op_nxt           = op_q;
    off_nxt          = off_q;
    wdata_nxt        = wdata_q;
    mem_addr_nxt     = mem_addr;
    resp_valid_nxt   = 1'b0;
    resp_err_nxt     = resp_err;
    resp_rdata_nxt   = resp_rdata;
    mem_write_en_nxt = 1'b0;
    for (int k = 0; k < NBYTES; k++) begin
      mem_data_in_nxt[k] = 8'h00;
    end

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          op_nxt    = req_op;
          off_nxt   = req_off_c;
          wdata_nxt = req_wdata[15:0];
          if (misaligned_c) begin
            state_nxt      = S_RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_rdata_nxt = '0;
          end else begin
            mem_addr_nxt = {req_addr[XLEN-1:OFF_W], OFF_W'(0)};
            if (req_op == OP_SF) begin
              state_nxt        = S_WRITE;
              mem_write_en_nxt = 1'b1;
              mem_data_in_nxt  = sf_lanes_c;
            end else begin
              state_nxt = S_RD_WAIT;
              cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
            end
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt == '0) begin
          if (is_load_q_c) begin
            state_nxt      = S_RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b0;
            resp_rdata_nxt = ld_result_c;
          end else begin
            // Sub-word store: merge new bytes into the word just read.
            state_nxt        = S_WRITE;
            mem_write_en_nxt = 1'b1;
            mem_data_in_nxt  = merge_lanes_c;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_WRITE: begin
        state_nxt      = S_RESP;
        resp_valid_nxt = 1'b1;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    req_ready_nxt = (state_nxt == S_IDLE);
    busy_nxt      = (state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_q         <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_rdata   <= '0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      for (int k = 0; k < NBYTES; k++) begin
        mem_data_in[k] <= 8'h00;
      end
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      op_q         <= op_nxt;
      off_q        <= off_nxt;
      wdata_q      <= wdata_nxt;
      req_ready    <= req_ready_nxt;
      busy         <= busy_nxt;
      resp_valid   <= resp_valid_nxt;
      resp_err     <= resp_err_nxt;
      resp_rdata   <= resp_rdata_nxt;
      mem_write_en <= mem_write_en_nxt;
      mem_addr     <= mem_addr_nxt;
      for (int k = 0; k < NBYTES; k++) begin
        mem_data_in[k] <= mem_data_in_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed bench for mips_lsu with a fixed-latency big-endian
// memory model and a response scoreboard.
module tb_mips_lsu;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NB    = 4;
  localparam int unsigned LAT   = 2;
  localparam int          BOUND = 40;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LF = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SF = 3'd7;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            req_valid, req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic            resp_valid, resp_err, busy, mem_write_en;
  logic [XLEN-1:0] resp_rdata, mem_addr;
  logic [7:0]      mem_data_out [0:NB-1];
  logic [7:0]      mem_data_in  [0:NB-1];

  always #5 clk = ~clk;

  mips_lsu #(.XLEN(XLEN), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_write_en(mem_write_en)
  );

  // Memory model: read data appears LAT cycles after the address is presented.
  logic [31:0] mem  [0:255];
  logic [31:0] pipe [0:LAT-1];
  logic [31:0] rd_word, out_word, din_word;
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;

  assign rd_word  = mem[8'(mem_addr >> 2)];
  assign out_word = pipe[LAT-2];
  assign din_word = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};

  always_comb begin
    for (int k = 0; k < NB; k++) mem_data_out[k] = out_word[31-8*k -: 8];
  end

  always @(posedge clk) begin
    if (mem_write_en) mem[8'(mem_addr >> 2)] <= din_word;
    else if (pre_we)  mem[8'(pre_addr >> 2)] <= pre_data;
    pipe[0] <= rd_word;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request from a negedge; returns at the negedge where resp_valid is seen.
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, input logic [31:0] exp_rdata, input bit exp_err,
                        input int exp_lat, output int wait_n, output int wcnt, output int wlat,
                        output logic [31:0] wword, output logic [31:0] waddr);
    exp_t e;
    int   lat;
    bit   got;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wait_n = 0; wcnt = 0; wlat = 0; wword = '0; waddr = '0; lat = 0; got = 1'b0;
    while (!req_ready && wait_n < BOUND) begin
      @(negedge clk);
      wait_n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{rdata: exp_rdata, err: exp_err, lat: 8'(exp_lat)});
    while (!got && lat < BOUND) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold) req_valid = 1'b0;
      if (mem_write_en) begin
        wcnt++; wlat = lat; wword = din_word; waddr = mem_addr;
      end
      if (resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    chk("resp_seen", 32'(got), 32'd1);
    chk("rdata", resp_rdata, e.rdata);
    chk("err", 32'(resp_err), 32'(e.err));
    chk("latency", 32'(lat), 32'(e.lat));
    chk("din_idle", din_word, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wn, wc, wl, quiet_bad;
    logic [31:0] ww, wa;

    rst_b = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_write_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", din_word, 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Full-word load
    preload(32'h100, 32'hDEADBEEF);
    do_req(LF, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    chk("lf_accept_wait", 32'(wn), 32'd0);
    chk("lf_no_write", 32'(wc), 32'd0);

    // Byte/half loads, signed vs unsigned
    preload(32'h100, 32'h91223380);
    do_req(LB,  32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    do_req(LBU, 32'h103, 32'h0, 1'b0, 32'h00000080, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    do_req(LB,  32'h101, 32'h0, 1'b0, 32'h00000022, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    do_req(LH,  32'h100, 32'h0, 1'b0, 32'hFFFF9122, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    do_req(LHU, 32'h100, 32'h0, 1'b0, 32'h00009122, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    do_req(LH,  32'h102, 32'h0, 1'b0, 32'h00003380, 1'b0, LAT+1, wn, wc, wl, ww, wa);

    // Sub-word stores (read-modify-write)
    preload(32'h100, 32'h11223344);
    do_req(SB, 32'h102, 32'h123456AA, 1'b0, 32'h0, 1'b0, LAT+2, wn, wc, wl, ww, wa);
    chk("sb_write_count", 32'(wc), 32'd1);
    chk("sb_write_cycle", 32'(wl), 32'(LAT+1));
    chk("sb_write_data", ww, 32'h1122AA44);
    chk("sb_write_addr", wa, 32'h100);
    do_req(SH, 32'h102, 32'h5555BEEF, 1'b0, 32'h0, 1'b0, LAT+2, wn, wc, wl, ww, wa);
    chk("sh_lo_write_data", ww, 32'h1122BEEF);
    do_req(SH, 32'h100, 32'h0000CAFE, 1'b0, 32'h0, 1'b0, LAT+2, wn, wc, wl, ww, wa);
    chk("sh_hi_write_data", ww, 32'hCAFEBEEF);
    do_req(LF, 32'h100, 32'h0, 1'b0, 32'hCAFEBEEF, 1'b0, LAT+1, wn, wc, wl, ww, wa);

    // Misaligned accesses: error the cycle after accept, no memory write
    do_req(LH,  32'h101, 32'h0,       1'b0, 32'h0, 1'b1, 1, wn, wc, wl, ww, wa);
    chk("mis_lh_no_write", 32'(wc), 32'd0);
    do_req(SF,  32'h102, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 1, wn, wc, wl, ww, wa);
    chk("mis_sf_no_write", 32'(wc), 32'd0);
    do_req(SH,  32'h103, 32'h0000FFFF, 1'b0, 32'h0, 1'b1, 1, wn, wc, wl, ww, wa);
    chk("mis_sh_no_write", 32'(wc), 32'd0);
    do_req(LF,  32'h101, 32'h0,       1'b0, 32'h0, 1'b1, 1, wn, wc, wl, ww, wa);
    do_req(LF,  32'h100, 32'h0,       1'b0, 32'hCAFEBEEF, 1'b0, LAT+1, wn, wc, wl, ww, wa);

    // Reset during RD_WAIT of an SH aborts it
    preload(32'h104, 32'h01020304);
    req_op = SH; req_addr = 32'h104; req_wdata = 32'h00007777; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    // Reset dominates a request presented on the same edge
    req_op = LF; req_addr = 32'h100; req_valid = 1'b1; rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1; req_valid = 1'b0;
    chk("rst_dominates_busy", 32'(busy), 32'd0);
    quiet_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_write_en || resp_valid) quiet_bad++;
    end
    chk("abort_quiet", 32'(quiet_bad), 32'd0);
    do_req(LF, 32'h104, 32'h0, 1'b0, 32'h01020304, 1'b0, LAT+1, wn, wc, wl, ww, wa);

    // Back-to-back SF then LF with req_valid held throughout
    do_req(SF, 32'h200, 32'hA5A50F0F, 1'b1, 32'h0, 1'b0, 2, wn, wc, wl, ww, wa);
    chk("sf_write_count", 32'(wc), 32'd1);
    chk("sf_write_cycle", 32'(wl), 32'd1);
    chk("sf_write_data", ww, 32'hA5A50F0F);
    chk("sf_write_addr", wa, 32'h200);
    do_req(LF, 32'h200, 32'h0, 1'b0, 32'hA5A50F0F, 1'b0, LAT+1, wn, wc, wl, ww, wa);
    chk("b2b_accept_wait", 32'(wn), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
